// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction-memory request, parks a stalled
// response in a hold buffer, drains in-flight requests after a redirect and feeds IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] IFID_instr,
  output logic [31:0] IFID_PCplus4,
  output logic        IFID_valid
);

  typedef enum logic [1:0] {
    REQ,
    HOLD,
    DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] holdBuf_q, holdBuf_d;
  logic [31:0] redirPc_q, redirPc_d;
  logic [31:0] ifidInstr_q, ifidInstr_d;
  logic [31:0] ifidPcPlus4_q, ifidPcPlus4_d;
  logic        ifidValid_q, ifidValid_d;

  logic        accept;
  logic        deliver;
  logic [31:0] deliverInstr;
  logic [31:0] pcPlus4;

  assign accept  = PCWrite & IFIDWrite;
  assign pcPlus4 = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    holdBuf_d    = holdBuf_q;
    redirPc_d    = redirPc_q;
    deliver      = 1'b0;
    deliverInstr = 32'd0;
    case (state_q)
      REQ: begin
        if (imem_ack) begin
          if (PCSrc) begin
            pc_d = BranchTarget;
          end else if (accept) begin
            deliver      = 1'b1;
            deliverInstr = imem_rdata;
            pc_d         = pcPlus4;
          end else begin
            holdBuf_d = imem_rdata;
            state_d   = HOLD;
          end
        end else if (PCSrc) begin
          // The request already on the bus cannot be withdrawn, so wait it out.
          redirPc_d = BranchTarget;
          state_d   = DRAIN;
        end
      end
      HOLD: begin
        if (PCSrc) begin
          pc_d      = BranchTarget;
          holdBuf_d = 32'd0;
          state_d   = REQ;
        end else if (accept) begin
          deliver      = 1'b1;
          deliverInstr = holdBuf_q;
          pc_d         = pcPlus4;
          state_d      = REQ;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          pc_d    = PCSrc ? BranchTarget : redirPc_q;
          state_d = REQ;
        end else if (PCSrc) begin
          redirPc_d = BranchTarget;
        end
      end
      default: state_d = REQ;
    endcase
  end

  // A parked instruction in HOLD keeps IF/ID frozen until the hazard clears.
  always_comb begin
    ifidInstr_d   = ifidInstr_q;
    ifidPcPlus4_d = ifidPcPlus4_q;
    ifidValid_d   = ifidValid_q;
    if (PCSrc) begin
      ifidInstr_d = 32'd0;
      ifidValid_d = 1'b0;
    end else if (deliver) begin
      ifidInstr_d   = deliverInstr;
      ifidPcPlus4_d = pcPlus4;
      ifidValid_d   = 1'b1;
    end else if (IFIDWrite && (state_q != HOLD)) begin
      ifidInstr_d = 32'd0;
      ifidValid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= REQ;
      pc_q          <= RESET_PC;
      holdBuf_q     <= 32'd0;
      redirPc_q     <= 32'd0;
      ifidInstr_q   <= 32'd0;
      ifidPcPlus4_q <= 32'd0;
      ifidValid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      holdBuf_q     <= holdBuf_d;
      redirPc_q     <= redirPc_d;
      ifidInstr_q   <= ifidInstr_d;
      ifidPcPlus4_q <= ifidPcPlus4_d;
      ifidValid_q   <= ifidValid_d;
    end
  end

  assign imem_req     = reset && (state_q != HOLD);
  assign imem_addr    = pc_q;
  assign PC           = pc_q;
  assign IFID_instr   = ifidInstr_q;
  assign IFID_PCplus4 = ifidPcPlus4_q;
  assign IFID_valid   = ifidValid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written redirect/wrap
// sequences and a randomized run against a transaction-level reference model.
module tb_fetch_stage;

  logic        clock;
  logic        reset, PCWrite, IFIDWrite, PCSrc, imem_ack;
  logic [31:0] BranchTarget, imem_rdata;
  logic        imem_req, IFID_valid;
  logic [31:0] imem_addr, PC, IFID_instr, IFID_PCplus4;
  logic        wReq, wValid;
  logic [31:0] wAddr, wPc, wInstr, wPcPlus4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, pcw, ifw, src, ack;
    logic [31:0] bt, rdata;
  } stim_t;

  typedef struct {
    stim_t       stim;
    logic        expReq, expValid;
    logic [31:0] expAddr, expInstr, expP4, expPc;
  } vector_t;

  vector_t vectors[$];

  // Reference model: a fetch is either outstanding, squashed (redirect pending), or parked.
  logic        mHave, mSquash, mValid;
  logic [31:0] mPc, mBuf, mRedir, mInstr, mP4;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC(PC),
    .IFID_instr(IFID_instr), .IFID_PCplus4(IFID_PCplus4), .IFID_valid(IFID_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clock(clock), .reset(reset), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget), .imem_req(wReq),
    .imem_addr(wAddr), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC(wPc),
    .IFID_instr(wInstr), .IFID_PCplus4(wPcPlus4), .IFID_valid(wValid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic stim_t mkStim(input logic rst, pcw, ifw, src, input logic [31:0] bt,
                                   input logic ack, input logic [31:0] rdata);
    stim_t s;
    s.rst = rst; s.pcw = pcw; s.ifw = ifw; s.src = src;
    s.bt = bt; s.ack = ack; s.rdata = rdata;
    return s;
  endfunction

  function automatic vector_t mkVec(input stim_t s, input logic expReq,
                                    input logic [31:0] expAddr, expInstr, expP4,
                                    input logic expValid, input logic [31:0] expPc);
    vector_t v;
    v.stim = s; v.expReq = expReq; v.expAddr = expAddr; v.expInstr = expInstr;
    v.expP4 = expP4; v.expValid = expValid; v.expPc = expPc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    @(negedge clock);
    reset        = s.rst;
    PCWrite      = s.pcw;
    IFIDWrite    = s.ifw;
    PCSrc        = s.src;
    BranchTarget = s.bt;
    imem_ack     = s.ack;
    imem_rdata   = s.rdata;
    #1;
  endtask

  task automatic modelEdge(input stim_t s);
    logic        got, avail;
    logic [31:0] inst;
    if (!s.rst) begin
      mPc = 32'd0; mHave = 1'b0; mSquash = 1'b0; mBuf = 32'd0; mRedir = 32'd0;
      mInstr = 32'd0; mP4 = 32'd0; mValid = 1'b0;
      return;
    end
    got = s.ack && !mHave;
    if (s.src) begin
      mInstr = 32'd0; mValid = 1'b0;
      if (mHave) begin
        mHave = 1'b0; mPc = s.bt;
      end else if (got) begin
        mSquash = 1'b0; mPc = s.bt;
      end else begin
        mSquash = 1'b1; mRedir = s.bt;
      end
    end else if (mSquash) begin
      if (got) begin
        mSquash = 1'b0; mPc = mRedir;
      end
      if (s.ifw) begin
        mInstr = 32'd0; mValid = 1'b0;
      end
    end else begin
      avail = mHave || got;
      inst  = mHave ? mBuf : s.rdata;
      if (avail && s.pcw && s.ifw) begin
        mInstr = inst; mP4 = mPc + 32'd4; mValid = 1'b1; mPc = mPc + 32'd4; mHave = 1'b0;
      end else if (avail && !mHave) begin
        mHave = 1'b1; mBuf = inst;
        if (s.ifw) begin
          mInstr = 32'd0; mValid = 1'b0;
        end
      end else if (!avail && s.ifw) begin
        mInstr = 32'd0; mValid = 1'b0;
      end
    end
  endtask

  task automatic modelStep(input string tag, input stim_t s);
    logic expReq;
    applyStimulus(s);
    expReq = s.rst && !mHave;
    checkOutput({tag, " req"}, 32'(imem_req), 32'(expReq));
    if (expReq) checkOutput({tag, " addr"}, imem_addr, mPc);
    @(posedge clock);
    #1;
    modelEdge(s);
    checkOutput({tag, " instr"}, IFID_instr, mInstr);
    checkOutput({tag, " pc4"}, IFID_PCplus4, mP4);
    checkOutput({tag, " valid"}, 32'(IFID_valid), 32'(mValid));
    checkOutput({tag, " pc"}, PC, mPc);
  endtask

  initial begin
    int age;
    stim_t s;
    logic expReq, stall;

    // Streaming, stall in HOLD, and redirect-over-stall priority.
    vectors.push_back(mkVec(mkStim(0,0,0,0,0,0,0),              0, 0,      0, 0,     0, 0));
    vectors.push_back(mkVec(mkStim(1,1,1,0,0,0,0),              1, 0,      0, 0,     0, 0));
    vectors.push_back(mkVec(mkStim(1,1,1,0,0,1,32'h1111_1111),  1, 0,      32'h1111_1111, 4, 1, 4));
    vectors.push_back(mkVec(mkStim(1,1,1,0,0,0,0),              1, 4,      0, 4,     0, 4));
    vectors.push_back(mkVec(mkStim(1,1,1,0,0,1,32'h2222_2222),  1, 4,      32'h2222_2222, 8, 1, 8));
    vectors.push_back(mkVec(mkStim(1,1,1,0,0,0,0),              1, 8,      0, 8,     0, 8));
    vectors.push_back(mkVec(mkStim(1,1,1,0,0,1,32'h3333_3333),  1, 8,      32'h3333_3333, 12, 1, 12));
    vectors.push_back(mkVec(mkStim(1,1,1,0,0,0,0),              1, 12,     0, 12,    0, 12));
    vectors.push_back(mkVec(mkStim(1,1,1,0,0,1,32'h4444_4444),  1, 12,     32'h4444_4444, 16, 1, 16));
    vectors.push_back(mkVec(mkStim(1,1,1,0,0,0,0),              1, 16,     0, 16,    0, 16));
    vectors.push_back(mkVec(mkStim(1,0,0,0,0,1,32'h8C01_0000),  1, 16,     0, 16,    0, 16));
    vectors.push_back(mkVec(mkStim(1,0,0,0,0,0,0),              0, 0,      0, 16,    0, 16));
    vectors.push_back(mkVec(mkStim(1,0,0,0,0,0,0),              0, 0,      0, 16,    0, 16));
    vectors.push_back(mkVec(mkStim(1,1,1,0,0,0,0),              0, 0,      32'h8C01_0000, 20, 1, 20));
    vectors.push_back(mkVec(mkStim(1,1,1,0,0,0,0),              1, 20,     0, 20,    0, 20));
    vectors.push_back(mkVec(mkStim(1,0,0,1,32'h100,1,32'hDEAD_BEEF), 1, 20, 0, 20,   0, 32'h100));
    vectors.push_back(mkVec(mkStim(1,1,1,0,0,0,0),              1, 32'h100, 0, 20,   0, 32'h100));

    for (int i = 0; i < vectors.size(); i++) begin
      applyStimulus(vectors[i].stim);
      checkOutput($sformatf("vec%0d req", i), 32'(imem_req), 32'(vectors[i].expReq));
      if (vectors[i].expReq) checkOutput($sformatf("vec%0d addr", i), imem_addr, vectors[i].expAddr);
      @(posedge clock);
      #1;
      checkOutput($sformatf("vec%0d instr", i), IFID_instr, vectors[i].expInstr);
      checkOutput($sformatf("vec%0d pc4", i), IFID_PCplus4, vectors[i].expP4);
      checkOutput($sformatf("vec%0d valid", i), 32'(IFID_valid), 32'(vectors[i].expValid));
      checkOutput($sformatf("vec%0d pc", i), PC, vectors[i].expPc);
    end

    // Wrap-around fetch on the second instance, then redirect while a request is in flight.
    modelStep("seq rst", mkStim(0,1,1,0,0,0,0));
    modelStep("seq go", mkStim(1,1,1,0,0,0,0));
    checkOutput("wrap first addr", wAddr, 32'hFFFF_FFFC);
    modelStep("seq ack0", mkStim(1,1,1,0,0,1,32'h0000_0013));
    checkOutput("wrap pc4", wPcPlus4, 32'd0);
    checkOutput("wrap valid", 32'(wValid), 32'd1);
    checkOutput("wrap next addr", wAddr, 32'd0);
    for (int k = 0; k < 3; k++) begin
      modelStep("seq idle", mkStim(1,1,1,0,0,0,0));
      modelStep("seq ack", mkStim(1,1,1,0,0,1,32'h0000_0100 + 32'(k)));
    end
    modelStep("redir", mkStim(1,1,1,1,32'h40,0,0));
    checkOutput("redir flush valid", 32'(IFID_valid), 32'd0);
    checkOutput("redir flush instr", IFID_instr, 32'd0);
    checkOutput("redir hold addr", imem_addr, 32'h10);
    modelStep("redir wait", mkStim(1,1,1,0,0,0,0));
    checkOutput("redir still addr", imem_addr, 32'h10);
    modelStep("redir ack", mkStim(1,1,1,0,0,1,32'hBAD0_BAD0));
    checkOutput("redir new addr", imem_addr, 32'h40);
    checkOutput("redir discard", 32'(IFID_valid), 32'd0);

    // Two redirects while draining: the newest target wins.
    modelStep("dbl1", mkStim(1,1,1,1,32'h40,0,0));
    modelStep("dbl2", mkStim(1,1,1,1,32'h80,0,0));
    checkOutput("dbl drain addr", imem_addr, 32'h40);
    modelStep("dbl ack", mkStim(1,1,1,0,0,1,32'h1234_5678));
    checkOutput("dbl pc", PC, 32'h80);
    checkOutput("dbl addr", imem_addr, 32'h80);

    // Randomized run with a memory that never acks in a request's first cycle.
    age = 0;
    for (int n = 0; n < 3000; n++) begin
      s.rst   = (n == 0 || $urandom_range(99) == 0) ? 1'b0 : 1'b1;
      stall   = ($urandom_range(3) == 0);
      s.pcw   = !stall;
      s.ifw   = !stall;
      s.src   = ($urandom_range(7) == 0);
      s.bt    = $urandom() & 32'hFFFF_FFFC;
      s.rdata = $urandom();
      expReq  = s.rst && !mHave;
      s.ack   = expReq && (age >= 1) && ($urandom_range(1) == 1);
      modelStep("rand", s);
      if (!s.rst || s.ack || !expReq) age = 0;
      else age++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports are named clock and reset.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-low reset, sampled on rising clock edge.
REQ-005 PCWrite  input  1  hazard-unit PC enable; 0 = stall.
REQ-006 IFIDWrite  input  1  hazard-unit IF/ID enable; 0 = stall.
REQ-007 PCSrc  input  1  taken branch, 1-cycle pulse; redirect and flush.
REQ-008 BranchTarget  input  32  redirect address, valid when PCSrc=1.
REQ-009 imem_req  output  1  instruction-memory request.
REQ-010 imem_addr  output  32  word address of the request.
REQ-011 imem_ack  input  1  1-cycle response strobe, never in the same cycle as req's first assertion.
REQ-012 imem_rdata  input  32  instruction, valid when imem_ack=1.
REQ-013 PC  output  32  current fetch PC.
REQ-014 IFID_instr  output  32  IF/ID instruction to decode/control_main.
REQ-015 IFID_PCplus4  output  32  IF/ID PC+4.
REQ-016 IFID_valid  output  1  IF/ID holds a real instruction.

Function
REQ-017 FSM states: REQ, HOLD, DRAIN.
REQ-018 Accept = PCWrite=1 and IFIDWrite=1; any other combination is a stall.
REQ-019 REQ: imem_req=1, imem_addr=PC.
- ack, no PCSrc, accept: IF/ID <= {imem_rdata, PC+4, valid=1}; PC <= PC+4; stay REQ.
- ack, no PCSrc, stall: capture imem_rdata in hold buffer; go HOLD.
REQ-020 HOLD: imem_req=0.
- accept: IF/ID <= {buffer, PC+4, 1}; PC <= PC+4; go REQ.
- stall: hold all state.
REQ-021 Once asserted, imem_req and imem_addr SHALL stay stable until imem_ack.
REQ-022 PCSrc=1 has priority over stall and over accept, in every state.
- IF/ID is flushed: instr=0, valid=0, PCplus4 unchanged.
REQ-023 PCSrc=1 in REQ with imem_ack=1: discard data; PC <= BranchTarget; stay REQ.
REQ-024 PCSrc=1 in REQ without imem_ack: RedirPC <= BranchTarget; go DRAIN.
REQ-025 PCSrc=1 in HOLD: drop buffer; PC <= BranchTarget; go REQ.
REQ-026 DRAIN: imem_req=1 at the old PC until ack; response is discarded.
- On ack: PC <= RedirPC; go REQ.
- Further PCSrc=1 in DRAIN overwrites RedirPC; newest target wins.
- If PCSrc coincides with ack, BranchTarget is used directly.
REQ-027 When IFIDWrite=1, no new instruction is available and PCSrc=0, IF/ID SHALL load a bubble (instr=0, valid=0).
REQ-028 When IFIDWrite=0 and PCSrc=0, IF/ID SHALL hold its value.
REQ-029 PC+4 is 32-bit modulo; the carry is discarded, so 32'hFFFF_FFFC+4 = 0.
REQ-030 PC is never modified during a stall except by PCSrc.
REQ-031 Output latency is 1 cycle: IF/ID updates on the edge where the qualifying ack or accept is sampled.

Reset
REQ-032 While reset=0 at a rising edge, the block SHALL reset to:
- PC=RESET_PC, state=REQ;
- IF/ID instr=0, PCplus4=0, valid=0;
- hold buffer and RedirPC = 0.
REQ-033 During reset, imem_req=0.
REQ-034 The first request SHALL be in the first cycle after reset=1.
REQ-035 Reset mid-transaction abandons it; a late imem_ack SHALL NOT load IF/ID.
- The bench guarantees no ack arrives after reset.

Verification
REQ-036 Streaming: reset release, ack on every 2nd cycle, no stalls.
- Expect imem_addr 0,4,8,12.
- Expect IFID_PCplus4 4,8,12,16.
- Expect valid pulses interleaved with bubbles.
REQ-037 Stall in HOLD: ack of 0x8C010000 while PCWrite=IFIDWrite=0 for 3 cycles.
- During the stall: IF/ID unchanged, imem_req=0.
- On release: IF/ID=0x8C010000, PC advances by 4.
REQ-038 Redirect in flight: PCSrc=1, BranchTarget=0x40 while REQ at PC=0x10 is unacked.
- imem_req stays at 0x10 until ack; that data is discarded.
- Next request is at 0x40; IF/ID is flushed.
REQ-039 Double redirect in DRAIN: targets 0x40 then 0x80 before ack.
- Next fetch is at 0x80.
REQ-040 Priority: PCSrc=1 with stall and ack in the same cycle.
- Expect flush, PC=BranchTarget, state REQ.
REQ-041 Wrap: RESET_PC=32'hFFFF_FFFC, one fetch.
- Expect IFID_PCplus4=0 and next imem_addr=0.
